// File: rtl/pic_8259.sv
// Simplified 8259 interrupt controller: one level, no cascade, fixed priority (bit 0 highest).
// Programmed through a command/mask port pair using the toggle-handshake I/O bus.
module pic_8259 #(
    parameter logic [11:0] BASE = 12'h020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] port,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        cpu_iordin,
    output logic        cpu_iordout,
    input  logic        cpu_iowrin,
    output logic        cpu_iowrout,
    input  logic [7:0]  irq,
    output logic        intr,
    input  logic        cpu_intain,
    output logic        cpu_intaout,
    output logic [7:0]  vector
);
    typedef enum logic [1:0] {READY, ICW2, ICW3, ICW4} state_t;

    state_t     state, state_nxt;
    logic [7:0] imr, irr, isr, irq_d;
    logic [4:0] vbase;
    logic       aeoi, rsel, sngl, ic4;
    logic       cs0, cs1;

    logic iowr, inta, wr0, wr1, icw1;
    assign iowr = cpu_iowrin ^ cpu_iowrout;
    assign inta = cpu_intain ^ cpu_intaout;
    assign wr0  = iowr & cs0;
    assign wr1  = iowr & cs1;
    assign icw1 = wr0 & din[4];

    logic imr_wr, vbase_wr, aeoi_wr, ocw2, ocw3;

    // ICW1 restarts the sequence from any state; operation commands only act in READY.
    always_comb begin
        state_nxt = state;
        imr_wr    = 1'b0;
        vbase_wr  = 1'b0;
        aeoi_wr   = 1'b0;
        ocw2      = 1'b0;
        ocw3      = 1'b0;
        if (icw1) begin
            state_nxt = ICW2;
        end else begin
            case (state)
                READY: begin
                    imr_wr = wr1;
                    ocw2   = wr0 && din[4:3] == 2'b00 && din[5];
                    ocw3   = wr0 && din[4:3] == 2'b01 && din[1];
                end
                ICW2: if (wr1) begin
                    vbase_wr  = 1'b1;
                    state_nxt = !sngl ? ICW3 : (ic4 ? ICW4 : READY);
                end
                ICW3: if (wr1) state_nxt = ic4 ? ICW4 : READY;
                ICW4: if (wr1) begin
                    aeoi_wr   = 1'b1;
                    state_nxt = READY;
                end
                default: state_nxt = READY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= READY;
        else       state <= state_nxt;
    end

    // Lowest pending unmasked request; it qualifies only if nothing of equal
    // or higher priority is already in service.
    logic [7:0] pend;
    logic [2:0] n;
    logic       found, blocked, qual;
    always_comb begin
        pend    = irr & ~imr;
        n       = 3'd0;
        found   = 1'b0;
        blocked = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (pend[i]) begin
                n     = 3'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (isr[i] && i <= int'(n)) blocked = 1'b1;
        end
        qual = found & ~blocked;
    end

    logic [7:0] eoi_clr, isr_eoi, ack_bit, edges;
    logic       ack;
    always_comb begin
        eoi_clr = 8'h00;
        if (ocw2) eoi_clr = din[6] ? (8'h01 << din[2:0]) : (isr & (~isr + 8'd1));
        isr_eoi = isr & ~eoi_clr;
        ack     = inta & qual;
        ack_bit = ack ? (8'h01 << n) : 8'h00;
        edges   = irq & ~irq_d;
    end

    always_ff @(posedge clk) begin
        irq_d       <= irq;
        cpu_iordout <= cpu_iordin;
        cpu_iowrout <= cpu_iowrin;
        cpu_intaout <= cpu_intain;
        cs0         <= port == BASE;
        cs1         <= port == BASE + 12'd1;
        if (reset) begin
            imr    <= 8'hFF;
            irr    <= 8'h00;
            isr    <= 8'h00;
            vbase  <= 5'h01;
            aeoi   <= 1'b0;
            rsel   <= 1'b0;
            sngl   <= 1'b0;
            ic4    <= 1'b0;
            intr   <= 1'b0;
            dout   <= 8'hFF;
            vector <= 8'hFF;
        end else begin
            if (icw1) begin
                imr  <= 8'h00;
                isr  <= 8'h00;
                irr  <= edges;
                aeoi <= 1'b0;
                rsel <= 1'b0;
                sngl <= din[1];
                ic4  <= din[0];
            end else begin
                if (imr_wr) imr <= din;
                if (ocw3)   rsel <= din[0];
                // New edges win over the acknowledge clear of the same bit.
                irr <= (irr & ~ack_bit) | edges;
                isr <= isr_eoi | (aeoi ? 8'h00 : ack_bit);
            end
            if (vbase_wr) vbase <= din[7:3];
            if (aeoi_wr)  aeoi  <= din[1];
            intr <= qual;
            if (inta) vector <= qual ? {vbase, n} : {vbase, 3'd7};
            dout <= cs0 ? (rsel ? isr : irr) : (cs1 ? imr : 8'hFF);
        end
    end
endmodule

// File: tb/tb_pic_8259.sv
// Directed bench for pic_8259: init sequence, priority, EOI, masking, spurious ack, reset mid-init.
module tb_pic_8259;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] port = 12'h000;
    logic [7:0]  din = 8'h00;
    logic [7:0]  dout;
    logic        cpu_iordin = 1'b0, cpu_iordout;
    logic        cpu_iowrin = 1'b0, cpu_iowrout;
    logic [7:0]  irq = 8'h00;
    logic        intr;
    logic        cpu_intain = 1'b0, cpu_intaout;
    logic [7:0]  vector;

    int n_checks = 0;
    int n_fail   = 0;

    pic_8259 #(.BASE(12'h020)) dut (
        .clk(clk), .reset(reset), .port(port), .din(din), .dout(dout),
        .cpu_iordin(cpu_iordin), .cpu_iordout(cpu_iordout),
        .cpu_iowrin(cpu_iowrin), .cpu_iowrout(cpu_iowrout),
        .irq(irq), .intr(intr),
        .cpu_intain(cpu_intain), .cpu_intaout(cpu_intaout),
        .vector(vector)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [11:0] a, input logic [7:0] d);
        port = a;
        din  = d;
        tick();
        cpu_iowrin = ~cpu_iowrin;
        tick();
        port = 12'h000;
    endtask

    task automatic io_read(input logic [11:0] a, output logic [7:0] d);
        port = a;
        tick();
        cpu_iordin = ~cpu_iordin;
        tick();
        d    = dout;
        port = 12'h000;
    endtask

    task automatic do_inta(output logic [7:0] v);
        cpu_intain = ~cpu_intain;
        tick();
        v = vector;
    endtask

    task automatic test_reset();
        logic [7:0] r;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL reset_intr: got %b exp 0", intr); end
        n_checks++; if (dout !== 8'hFF) begin n_fail++; $display("FAIL reset_dout: got %h exp ff", dout); end
        io_read(12'h021, r);
        n_checks++; if (r !== 8'hFF) begin n_fail++; $display("FAIL reset_imr: got %h exp ff", r); end
        io_write(12'h021, 8'h00);
        io_read(12'h021, r);
        n_checks++; if (r !== 8'h00) begin n_fail++; $display("FAIL imr_write: got %h exp 00", r); end
    endtask

    task automatic test_init_and_ack();
        logic [7:0] r;
        io_write(12'h020, 8'h13);
        io_write(12'h021, 8'h08);
        io_write(12'h021, 8'h01);
        io_read(12'h021, r);
        n_checks++; if (r !== 8'h00) begin n_fail++; $display("FAIL init_imr: got %h exp 00", r); end
        irq[0] = 1'b1;
        tick();
        n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL intr_early: got %b exp 0", intr); end
        tick();
        n_checks++; if (intr !== 1'b1) begin n_fail++; $display("FAIL intr_rise: got %b exp 1", intr); end
        irq[0] = 1'b0;
        do_inta(r);
        n_checks++; if (r !== 8'h08) begin n_fail++; $display("FAIL vec_irq0: got %h exp 08", r); end
        tick();
        n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL intr_drop: got %b exp 0", intr); end
        io_write(12'h020, 8'h0B);
        io_read(12'h020, r);
        n_checks++; if (r !== 8'h01) begin n_fail++; $display("FAIL isr_irq0: got %h exp 01", r); end
        io_write(12'h020, 8'h0A);
    endtask

    task automatic test_nonspecific_eoi();
        logic [7:0] r;
        irq[3] = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL blocked_by_isr: got %b exp 0", intr); end
        irq[3] = 1'b0;
        io_write(12'h020, 8'h20);
        tick();
        n_checks++; if (intr !== 1'b1) begin n_fail++; $display("FAIL intr_after_eoi: got %b exp 1", intr); end
        do_inta(r);
        n_checks++; if (r !== 8'h0B) begin n_fail++; $display("FAIL vec_irq3: got %h exp 0b", r); end
        io_write(12'h020, 8'h20);
    endtask

    task automatic test_back_to_back();
        logic [7:0] r;
        irq[5] = 1'b1;
        irq[2] = 1'b1;
        tick();
        irq = 8'h00;
        tick();
        n_checks++; if (intr !== 1'b1) begin n_fail++; $display("FAIL intr_two: got %b exp 1", intr); end
        do_inta(r);
        n_checks++; if (r !== 8'h0A) begin n_fail++; $display("FAIL vec_irq2: got %h exp 0a", r); end
        io_write(12'h020, 8'h20);
        do_inta(r);
        n_checks++; if (r !== 8'h0D) begin n_fail++; $display("FAIL vec_irq5: got %h exp 0d", r); end
        io_write(12'h020, 8'h0B);
        io_read(12'h020, r);
        n_checks++; if (r !== 8'h20) begin n_fail++; $display("FAIL isr_irq5: got %h exp 20", r); end
        io_write(12'h020, 8'h0A);
        io_write(12'h020, 8'h20);
        io_write(12'h020, 8'h0B);
        io_read(12'h020, r);
        n_checks++; if (r !== 8'h00) begin n_fail++; $display("FAIL isr_cleared: got %h exp 00", r); end
        io_write(12'h020, 8'h0A);
    endtask

    task automatic test_mask_and_spurious();
        logic [7:0] r;
        io_write(12'h021, 8'h01);
        irq[0] = 1'b1;
        tick(); tick();
        irq[0] = 1'b0;
        tick();
        n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL masked_intr: got %b exp 0", intr); end
        io_read(12'h020, r);
        n_checks++; if (r !== 8'h01) begin n_fail++; $display("FAIL masked_irr: got %h exp 01", r); end
        io_write(12'h021, 8'h00);
        tick();
        n_checks++; if (intr !== 1'b1) begin n_fail++; $display("FAIL unmask_intr: got %b exp 1", intr); end
        io_write(12'h020, 8'h13);
        tick();
        n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL icw1_intr: got %b exp 0", intr); end
        do_inta(r);
        n_checks++; if (r !== 8'h0F) begin n_fail++; $display("FAIL vec_spurious: got %h exp 0f", r); end
        io_write(12'h021, 8'h08);
        io_write(12'h021, 8'h01);
    endtask

    task automatic test_reset_mid_init();
        logic [7:0] r;
        io_write(12'h020, 8'h11);
        io_write(12'h021, 8'h20);
        reset = 1'b1;
        port  = 12'h021;
        din   = 8'h55;
        cpu_iowrin = ~cpu_iowrin;
        tick(); tick();
        reset = 1'b0;
        tick();
        n_checks++; if (cpu_iowrout !== cpu_iowrin) begin n_fail++; $display("FAIL reset_hs: got %b exp %b", cpu_iowrout, cpu_iowrin); end
        port = 12'h000;
        io_read(12'h021, r);
        n_checks++; if (r !== 8'hFF) begin n_fail++; $display("FAIL mid_reset_imr: got %h exp ff", r); end
        io_write(12'h021, 8'h00);
        io_read(12'h021, r);
        n_checks++; if (r !== 8'h00) begin n_fail++; $display("FAIL mid_reset_ready: got %h exp 00", r); end
        irq[1] = 1'b1;
        tick(); tick();
        irq[1] = 1'b0;
        do_inta(r);
        n_checks++; if (r !== 8'h09) begin n_fail++; $display("FAIL mid_reset_vbase: got %h exp 09", r); end
    endtask

    initial begin
        test_reset();
        test_init_and_ack();
        test_nonspecific_eoi();
        test_back_to_back();
        test_mask_and_spurious();
        test_reset_mid_init();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
